// File: rtl/roulette_pkg.sv
// Shared roulette LED layout constants, encoder state/class enums and fault codes.
// Combinational definitions only; no latency or backpressure of its own.
package roulette_pkg;

  localparam int NUM_LEDS       = 38;
  localparam int NUM_GROUPS     = 6;
  localparam int LEDS_PER_GROUP = 7;

  typedef logic [NUM_GROUPS-1:0][2:0] sel_bus_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUALIFY,
    ST_REPORT,
    ST_HOLDOFF,
    ST_FAULT
  } enc_state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_VALID,
    CLS_MULTI,
    CLS_RANGE
  } sel_class_e;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_MULTI = 2'b01;
  localparam logic [1:0] FC_RANGE = 2'b10;

endpackage

// File: rtl/led_position_encoder_if.sv
// Select-bus inputs, position valid/ready handshake and fault flags of the encoder.
// slave = encoder side; master = sensor/controller side driving selects, ready and clear.
interface led_position_encoder_if;

  logic [2:0] mux_select_0;
  logic [2:0] mux_select_1;
  logic [2:0] mux_select_2;
  logic [2:0] mux_select_3;
  logic [2:0] mux_select_4;
  logic [2:0] mux_select_5;
  logic       sample_en;
  logic [5:0] led_number;
  logic       led_valid;
  logic       led_ready;
  logic       fault;
  logic [1:0] fault_code;
  logic       fault_clr;

  modport master (
    output mux_select_0, mux_select_1, mux_select_2,
    output mux_select_3, mux_select_4, mux_select_5,
    output sample_en, led_ready, fault_clr,
    input  led_number, led_valid, fault, fault_code
  );

  modport slave (
    input  mux_select_0, mux_select_1, mux_select_2,
    input  mux_select_3, mux_select_4, mux_select_5,
    input  sample_en, led_ready, fault_clr,
    output led_number, led_valid, fault, fault_code
  );

endinterface

// File: rtl/led_select_classify.sv
// Classifies six group select codes into NONE/VALID/MULTI/RANGE plus candidate LED number.
// Purely combinational, zero latency; no backpressure.
module led_select_classify
  import roulette_pkg::*;
(
  input  sel_bus_t   i_sel,
  output sel_class_e o_class,
  output logic [5:0] o_cand
);

  logic       w_any;
  logic       w_multi;
  logic [5:0] w_raw;

  // w_multi rises on the second nonzero group seen in the scan
  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    w_raw   = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (i_sel[g] != 3'd0) begin
        w_multi = w_multi | w_any;
        w_any   = 1'b1;
        w_raw   = 6'(g * LEDS_PER_GROUP) + {3'b000, i_sel[g]} - 6'd1;
      end
    end
  end

  // Candidate is forced to 0 for NONE/MULTI so those samples compare as stable
  always_comb begin
    o_class = CLS_NONE;
    o_cand  = '0;
    if (w_multi) begin
      o_class = CLS_MULTI;
    end else if (w_any) begin
      o_cand  = w_raw;
      o_class = (w_raw > 6'(NUM_LEDS - 1)) ? CLS_RANGE : CLS_VALID;
    end
  end

endmodule

// File: rtl/led_position_encoder.sv
// Debounces the group select bus and reports a settled LED position; valid after STABLE_CYCLES+1 edges.
// led_valid/led_number hold until led_ready; illegal patterns raise a sticky fault until fault_clr.
module led_position_encoder
  import roulette_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  led_position_encoder_if.slave bus
);

  sel_bus_t   r_sel;
  sel_class_e r_prev_class;
  logic [5:0] r_prev_cand;
  logic [CNT_W-1:0] r_cnt;
  enc_state_e r_state;
  logic [5:0] r_led_number;
  logic       r_led_valid;
  logic       r_fault;
  logic [1:0] r_fault_code;

  sel_bus_t   w_sel_in;
  sel_class_e w_class;
  logic [5:0] w_cand;
  logic       w_same;
  logic [CNT_W-1:0] w_cnt_next;
  logic       w_qualified;

  assign w_sel_in = {bus.mux_select_5, bus.mux_select_4, bus.mux_select_3,
                     bus.mux_select_2, bus.mux_select_1, bus.mux_select_0};

  led_select_classify u_classify (
    .i_sel   (r_sel),
    .o_class (w_class),
    .o_cand  (w_cand)
  );

  assign w_same = (w_class == r_prev_class) && (w_cand == r_prev_cand);

  // Entry from IDLE counts as the first stable sample, so latency holds even for STABLE_CYCLES=1
  always_comb begin
    w_cnt_next = CNT_W'(1);
    if (r_state == ST_QUALIFY && w_same) begin
      w_cnt_next = (r_cnt >= CNT_W'(STABLE_CYCLES)) ? CNT_W'(STABLE_CYCLES) : r_cnt + CNT_W'(1);
    end
  end

  assign w_qualified = (w_cnt_next >= CNT_W'(STABLE_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= '0;
      r_prev_class <= CLS_NONE;
      r_prev_cand  <= '0;
      r_cnt        <= '0;
      r_state      <= ST_IDLE;
      r_led_number <= '0;
      r_led_valid  <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
    end else begin
      r_sel <= w_sel_in;
      case (r_state)
        ST_IDLE, ST_QUALIFY: begin
          r_prev_class <= w_class;
          r_prev_cand  <= w_cand;
          if (!bus.sample_en || w_class == CLS_NONE) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_qualified) begin
            r_cnt <= '0;
            if (w_class == CLS_VALID) begin
              r_led_number <= w_cand;
              r_led_valid  <= 1'b1;
              r_state      <= ST_REPORT;
            end else begin
              r_fault      <= 1'b1;
              r_fault_code <= (w_class == CLS_MULTI) ? FC_MULTI : FC_RANGE;
              r_state      <= ST_FAULT;
            end
          end else begin
            r_cnt   <= w_cnt_next;
            r_state <= ST_QUALIFY;
          end
        end
        ST_REPORT: begin
          if (bus.led_ready) begin
            r_led_valid <= 1'b0;
            r_state     <= ST_HOLDOFF;
          end
        end
        // Wait for the reported position to go away before allowing a new report
        ST_HOLDOFF: begin
          if (w_class != CLS_VALID || w_cand != r_led_number) begin
            r_state <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (bus.fault_clr) begin
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.led_number = r_led_number;
  assign bus.led_valid  = r_led_valid;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;

endmodule

// File: tb/tb_led_position_encoder.sv
// Directed bench for led_position_encoder with a per-cycle behavioural reference.
// Reference tracks run length of identical samples and report/holdoff/fault flags.
module tb_led_position_encoder;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  bit seen9 = 1'b0;

  led_position_encoder_if bus ();

  led_position_encoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference: sample classes 0=none 1=valid 2=multi 3=range
  int  m_sel[6];
  int  m_run = 0, m_last_cls = 0, m_last_cand = 0, m_num = 0, m_code = 0;
  bit  m_vld = 1'b0, m_hold = 1'b0, m_flt = 1'b0;

  function automatic void classify(output int cls, output int cand);
    int active = 0;
    cand = 0;
    for (int g = 0; g < 6; g++) begin
      if (m_sel[g] != 0) begin
        active++;
        cand = g * 7 + m_sel[g] - 1;
      end
    end
    if (active == 0) cls = 0;
    else if (active > 1) begin cls = 2; cand = 0; end
    else if (cand > 37) cls = 3;
    else cls = 1;
  endfunction

  initial begin
    for (int g = 0; g < 6; g++) m_sel[g] = 0;
    forever begin
      int cls, cand;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int g = 0; g < 6; g++) m_sel[g] = 0;
        m_run = 0; m_vld = 1'b0; m_hold = 1'b0; m_flt = 1'b0; m_num = 0; m_code = 0;
        m_last_cls = 0; m_last_cand = 0;
      end else begin
        classify(cls, cand);
        if (m_vld) begin
          if (bus.led_ready) begin m_vld = 1'b0; m_hold = 1'b1; end
        end else if (m_hold) begin
          if (cls != 1 || cand != m_num) m_hold = 1'b0;
        end else if (m_flt) begin
          if (bus.fault_clr) begin m_flt = 1'b0; m_code = 0; end
        end else if (cls == 0 || !bus.sample_en) begin
          m_run = 0;
        end else begin
          if (m_run > 0 && cls == m_last_cls && cand == m_last_cand) m_run++;
          else m_run = 1;
          m_last_cls = cls;
          m_last_cand = cand;
          if (m_run >= STABLE) begin
            m_run = 0;
            if (cls == 1) begin m_vld = 1'b1; m_num = cand; end
            else begin m_flt = 1'b1; m_code = (cls == 2) ? 1 : 2; end
          end
        end
        m_sel[0] = int'(bus.mux_select_0); m_sel[1] = int'(bus.mux_select_1);
        m_sel[2] = int'(bus.mux_select_2); m_sel[3] = int'(bus.mux_select_3);
        m_sel[4] = int'(bus.mux_select_4); m_sel[5] = int'(bus.mux_select_5);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_led_valid", int'(bus.led_valid), int'(m_vld));
    chk("cyc_fault", int'(bus.fault), int'(m_flt));
    chk("cyc_fault_code", int'(bus.fault_code), m_code);
    if (m_vld) chk("cyc_led_number", int'(bus.led_number), m_num);
  end

  initial forever begin
    @(posedge clk);
    if (bus.led_valid && bus.led_number == 6'd9) seen9 = 1'b1;
  end

  task automatic put(input int ga, input int ca, input int gb = -1, input int cb = 0);
    logic [2:0] v[6];
    for (int g = 0; g < 6; g++) v[g] = 3'd0;
    if (ga >= 0) v[ga] = 3'(ca);
    if (gb >= 0) v[gb] = 3'(cb);
    bus.mux_select_0 = v[0]; bus.mux_select_1 = v[1]; bus.mux_select_2 = v[2];
    bus.mux_select_3 = v[3]; bus.mux_select_4 = v[4]; bus.mux_select_5 = v[5];
  endtask

  task automatic wait_valid(input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(posedge clk); #1;
      ok = bus.led_valid;
    end
    chk("wait_valid_timeout", int'(ok), 1);
  endtask

  task automatic wait_fault(input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(posedge clk); #1;
      ok = bus.fault;
    end
    chk("wait_fault_timeout", int'(ok), 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, int'(bus.led_valid), 0);
    chk({nm, "_number"}, int'(bus.led_number), 0);
    chk({nm, "_fault"}, int'(bus.fault), 0);
    chk({nm, "_code"}, int'(bus.fault_code), 0);
  endtask

  initial begin
    put(-1, 0);
    bus.sample_en = 1'b0;
    bus.led_ready = 1'b0;
    bus.fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // 1: group 2 code 5 -> 18, one-cycle pulse after E+4
    @(negedge clk);
    put(2, 5); bus.sample_en = 1'b1; bus.led_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("t1_early_valid", int'(bus.led_valid), 0);
    end
    @(posedge clk); #1;
    chk("t1_valid_at_e4", int'(bus.led_valid), 1);
    chk("t1_number", int'(bus.led_number), 18);
    @(posedge clk); #1;
    chk("t1_pulse_width", int'(bus.led_valid), 0);
    repeat (8) @(negedge clk);

    // 2: brief 9 then held 10
    put(1, 3);
    repeat (2) @(negedge clk);
    put(1, 4);
    wait_valid(20);
    chk("t2_number", int'(bus.led_number), 10);
    repeat (6) @(negedge clk);
    chk("t2_no_pos9", int'(seen9), 0);

    // 3: 37 held while ready low and input moves away
    bus.led_ready = 1'b0;
    put(5, 3);
    wait_valid(20);
    chk("t3_number", int'(bus.led_number), 37);
    repeat (3) @(negedge clk);
    put(0, 1);
    repeat (10) @(negedge clk);
    chk("t3_still_valid", int'(bus.led_valid), 1);
    chk("t3_still_37", int'(bus.led_number), 37);
    bus.led_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_handshake_drop", int'(bus.led_valid), 0);
    wait_valid(20);
    chk("t3_new_number", int'(bus.led_number), 0);

    // 4: two groups active -> multi fault, then clear
    @(negedge clk);
    put(0, 1, 3, 2);
    wait_fault(20);
    chk("t4_code", int'(bus.fault_code), 1);
    chk("t4_no_valid", int'(bus.led_valid), 0);
    @(negedge clk);
    put(-1, 0); bus.fault_clr = 1'b1;
    @(posedge clk); #1;
    chk("t4_cleared", int'(bus.fault), 0);
    chk("t4_code_cleared", int'(bus.fault_code), 0);
    @(negedge clk);
    bus.fault_clr = 1'b0;

    // 5: 38 out of range; clear while present re-faults; sample_en low suppresses
    put(5, 4);
    wait_fault(20);
    chk("t5_code", int'(bus.fault_code), 2);
    @(negedge clk);
    bus.fault_clr = 1'b1;
    @(posedge clk); #1;
    chk("t5_clear_wins", int'(bus.fault), 0);
    @(negedge clk);
    bus.fault_clr = 1'b0;
    wait_fault(20);
    chk("t5_refault_code", int'(bus.fault_code), 2);
    @(negedge clk);
    bus.sample_en = 1'b0; bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_disabled_no_fault", int'(bus.fault), 0);

    // 6: reset mid-REPORT and mid-QUALIFY
    bus.sample_en = 1'b1; bus.led_ready = 1'b0;
    put(4, 2);
    wait_valid(20);
    chk("t6_number", int'(bus.led_number), 29);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("t6_rst_report");
    repeat (2) @(negedge clk);
    rst_n = 1'b1; bus.led_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6_rst_qualify");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("t6_early_valid", int'(bus.led_valid), 0);
    end
    @(posedge clk); #1;
    chk("t6_valid_full_delay", int'(bus.led_valid), 1);
    chk("t6_number_after_rst", int'(bus.led_number), 29);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
